// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared state type and write-port arbitration for register_file_mp
package rf_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

  localparam int MAX_WPORTS = 16;
  localparam int MAX_ADDRW  = 16;
  localparam int WIDXW      = $clog2(MAX_WPORTS);

  typedef struct packed {
    logic             hit;
    logic             multi;
    logic [WIDXW-1:0] idx;
  } rf_win_t;

  // Later ports overwrite idx, so the highest enabled matching port wins; x0 never matches.
  function automatic rf_win_t rf_winner(
    input logic [MAX_WPORTS-1:0]           en,
    input logic [MAX_WPORTS*MAX_ADDRW-1:0] addrs,
    input logic [MAX_ADDRW-1:0]            addr
  );
    rf_win_t r;
    r = '0;
    for (int p = 0; p < MAX_WPORTS; p++) begin
      if (en[p] && (addrs[p*MAX_ADDRW +: MAX_ADDRW] == addr) && (addr != '0)) begin
        r.multi = r.multi | r.hit;
        r.hit   = 1'b1;
        r.idx   = WIDXW'(p);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// rtl/rf_clear_seq.sv - post-reset clear sequencer: walks x1..x(SIZE-1) to zero, then raises ready
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter  int SIZE  = 32,
  localparam int ADDRW = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             clr_en,
  output logic [ADDRW-1:0] clr_addr,
  output logic             ready
);

  rf_state_e        r_state;
  logic [ADDRW-1:0] r_clr_idx;
  logic             r_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= CLEAR;
      r_clr_idx <= ADDRW'(1);
      r_ready   <= 1'b0;
    end else if (r_state == CLEAR) begin
      r_clr_idx <= r_clr_idx + ADDRW'(1);
      if (r_clr_idx == ADDRW'(SIZE - 1)) begin
        r_state <= READY;
        r_ready <= 1'b1;
      end
    end
  end

  assign clr_en   = (r_state == CLEAR) && !reset;
  assign clr_addr = r_clr_idx;
  assign ready    = r_ready;

endmodule

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port integer register file with x0, bypass and collision flag
module register_file_mp
  import rf_pkg::*;
#(
  parameter  int WORDSIZE = 64,
  parameter  int SIZE     = 32,
  parameter  int NREAD    = 2,
  parameter  int NWRITE   = 1,
  parameter  int BYPASS   = 1,
  localparam int ADDRW    = $clog2(SIZE)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NWRITE-1:0]          write_en,
  input  logic [NWRITE*ADDRW-1:0]    write_addr,
  input  logic [NWRITE*WORDSIZE-1:0] write_data,
  input  logic [NREAD*ADDRW-1:0]     read_addr,
  output logic [NREAD*WORDSIZE-1:0]  read_data,
  output logic                       ready,
  output logic                       write_conflict
);

  logic                           w_clr_en;
  logic [ADDRW-1:0]               w_clr_addr;
  logic                           w_ready;
  logic [MAX_WPORTS-1:0]          w_en_pad;
  logic [MAX_WPORTS*MAX_ADDRW-1:0] w_addr_pad;
  rf_win_t                        w_win [SIZE];
  logic                           w_any_multi;
  logic [ADDRW-1:0]               w_ra [NREAD];
  logic [WORDSIZE-1:0]            r_mem [1:SIZE-1];
  logic                           r_conflict;

  rf_clear_seq #(.SIZE(SIZE)) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_en   (w_clr_en),
    .clr_addr (w_clr_addr),
    .ready    (w_ready)
  );

  // Enables are masked by ready so CLEAR ignores writes, bypass and conflicts in one place.
  always_comb begin
    w_en_pad   = '0;
    w_addr_pad = '0;
    for (int p = 0; p < NWRITE; p++) begin
      w_en_pad[p]                       = write_en[p] & w_ready;
      w_addr_pad[p*MAX_ADDRW +: ADDRW] = write_addr[p*ADDRW +: ADDRW];
    end
  end

  always_comb begin
    w_any_multi = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      w_win[i]    = rf_winner(w_en_pad, w_addr_pad, MAX_ADDRW'(i));
      w_any_multi = w_any_multi | w_win[i].multi;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 1; i < SIZE; i++) begin
      if (w_clr_en && (w_clr_addr == ADDRW'(i))) begin
        r_mem[i] <= '0;
      end else if (w_win[i].hit) begin
        r_mem[i] <= write_data[int'(w_win[i].idx)*WORDSIZE +: WORDSIZE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= w_any_multi;
    end
  end

  always_comb begin
    for (int q = 0; q < NREAD; q++) begin
      w_ra[q] = read_addr[q*ADDRW +: ADDRW];
    end
  end

  always_comb begin
    read_data = '0;
    for (int q = 0; q < NREAD; q++) begin
      if (w_ready && (w_ra[q] != '0)) begin
        if ((BYPASS != 0) && w_win[w_ra[q]].hit) begin
          read_data[q*WORDSIZE +: WORDSIZE] =
            write_data[int'(w_win[w_ra[q]].idx)*WORDSIZE +: WORDSIZE];
        end else begin
          read_data[q*WORDSIZE +: WORDSIZE] = r_mem[w_ra[q]];
        end
      end
    end
  end

  assign ready          = w_ready;
  assign write_conflict = r_conflict;

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - scoreboard bench for register_file_mp (bypass/2W4R and plain/1W2R)
module tb_register_file_mp;

  localparam int W  = 64;
  localparam int SZ = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      a_wen;
  logic [2*AW-1:0] a_waddr;
  logic [2*W-1:0]  a_wdata;
  logic [4*AW-1:0] a_raddr;
  logic [4*W-1:0]  a_rdata;
  logic            a_ready, a_conf;

  logic [0:0]      b_wen;
  logic [AW-1:0]   b_waddr;
  logic [W-1:0]    b_wdata;
  logic [2*AW-1:0] b_raddr;
  logic [2*W-1:0]  b_rdata;
  logic            b_ready, b_conf;

  register_file_mp #(.WORDSIZE(W), .SIZE(SZ), .NREAD(4), .NWRITE(2), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .write_en(a_wen), .write_addr(a_waddr), .write_data(a_wdata),
    .read_addr(a_raddr), .read_data(a_rdata), .ready(a_ready), .write_conflict(a_conf)
  );

  register_file_mp #(.WORDSIZE(W), .SIZE(SZ), .NREAD(2), .NWRITE(1), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .write_en(b_wen), .write_addr(b_waddr), .write_data(b_wdata),
    .read_addr(b_raddr), .read_data(b_rdata), .ready(b_ready), .write_conflict(b_conf)
  );

  typedef enum int {K_RDA, K_RDB, K_RDYA, K_RDYB, K_CFA, K_CFB} kind_e;
  typedef struct {
    string          tag;
    kind_e          kind;
    int             port;
    logic [W-1:0]   val;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] model_a [SZ];

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic expect_val(input string tag, input kind_e k, input int port, input logic [W-1:0] v);
    exp_t e;
    e.tag = tag; e.kind = k; e.port = port; e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [W-1:0] got;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RDA:   got = a_rdata[e.port*W +: W];
        K_RDB:   got = b_rdata[e.port*W +: W];
        K_RDYA:  got = 64'(a_ready);
        K_RDYB:  got = 64'(b_ready);
        K_CFA:   got = 64'(a_conf);
        K_CFB:   got = 64'(b_conf);
        default: got = 'x;
      endcase
      chk(e.tag, got, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_w(input int p, input logic en, input logic [AW-1:0] ad, input logic [W-1:0] d);
    a_wen[p] = en;
    a_waddr[p*AW +: AW] = ad;
    a_wdata[p*W +: W] = d;
  endtask

  task automatic b_w(input logic en, input logic [AW-1:0] ad, input logic [W-1:0] d);
    b_wen[0] = en;
    b_waddr  = ad;
    b_wdata  = d;
  endtask

  task automatic a_r(input int q, input logic [AW-1:0] ad);
    a_raddr[q*AW +: AW] = ad;
  endtask

  task automatic b_r(input int q, input logic [AW-1:0] ad);
    b_raddr[q*AW +: AW] = ad;
  endtask

  task automatic a_idle();
    a_w(0, 1'b0, '0, '0);
    a_w(1, 1'b0, '0, '0);
  endtask

  initial begin
    logic           e0, e1;
    logic [AW-1:0]  ad0, ad1;
    logic [W-1:0]   d0, d1, ev;
    logic [AW-1:0]  ra [4];

    a_wen = '0; a_waddr = '0; a_wdata = '0; a_raddr = '0;
    b_wen = '0; b_waddr = '0; b_wdata = '0; b_raddr = '0;
    for (int i = 0; i < SZ; i++) model_a[i] = '0;

    tick();
    tick();
    a_r(0, 5);
    b_r(0, 5);
    expect_val("rst_ready_a", K_RDYA, 0, 0);
    expect_val("rst_ready_b", K_RDYB, 0, 0);
    expect_val("rst_conf_a", K_CFA, 0, 0);
    expect_val("rst_conf_b", K_CFB, 0, 0);
    expect_val("rst_read_a", K_RDA, 0, 0);
    drain();

    reset = 1'b0;
    for (int e = 1; e <= 31; e++) begin
      tick();
      if (e == 10) begin
        a_idle();
        b_w(1'b0, '0, '0);
      end
      expect_val($sformatf("clr_ready_a_e%0d", e), K_RDYA, 0, 64'(e == 31));
      expect_val($sformatf("clr_ready_b_e%0d", e), K_RDYB, 0, 64'(e == 31));
      if (e < 31) begin
        expect_val($sformatf("clr_read_a_e%0d", e), K_RDA, 0, 0);
        expect_val($sformatf("clr_conf_a_e%0d", e), K_CFA, 0, 0);
      end
      drain();
      if (e == 9) begin
        a_w(0, 1'b1, 5, 64'hAA);
        a_w(1, 1'b1, 5, 64'hBB);
        b_w(1'b1, 5, 64'hAA);
        expect_val("clr_no_bypass_a", K_RDA, 0, 0);
        expect_val("clr_no_read_b", K_RDB, 0, 0);
        drain();
      end
    end
    expect_val("clr_wr_ignored_a", K_RDA, 0, 0);
    expect_val("clr_wr_ignored_b", K_RDB, 0, 0);
    expect_val("clr_conf_after_a", K_CFA, 0, 0);
    drain();

    b_w(1'b1, 3, 64'h1234);
    b_r(0, 3);
    expect_val("b_old_value", K_RDB, 0, 0);
    drain();
    tick();
    b_w(1'b0, '0, '0);
    expect_val("b_new_value", K_RDB, 0, 64'h1234);
    drain();
    b_w(1'b1, 0, 64'hFF);
    b_r(1, 0);
    expect_val("b_x0_same", K_RDB, 1, 0);
    drain();
    tick();
    b_w(1'b0, '0, '0);
    expect_val("b_x0_next", K_RDB, 1, 0);
    expect_val("b_conf", K_CFB, 0, 0);
    drain();

    a_w(0, 1'b1, 7, 64'hDEADBEEF);
    a_w(1, 1'b1, 0, 64'h55);
    a_r(0, 0); a_r(1, 7); a_r(2, 0); a_r(3, 7);
    expect_val("bp_port1", K_RDA, 1, 64'hDEADBEEF);
    expect_val("bp_port3", K_RDA, 3, 64'hDEADBEEF);
    expect_val("bp_x0_p0", K_RDA, 0, 0);
    expect_val("bp_x0_p2", K_RDA, 2, 0);
    drain();
    tick();
    a_idle();
    model_a[7] = 64'hDEADBEEF;
    expect_val("bp_stored", K_RDA, 1, 64'hDEADBEEF);
    expect_val("bp_conf", K_CFA, 0, 0);
    drain();

    a_w(0, 1'b1, 9, 64'h11);
    a_w(1, 1'b1, 9, 64'h22);
    a_r(0, 9);
    expect_val("col_bypass", K_RDA, 0, 64'h22);
    drain();
    tick();
    a_idle();
    model_a[9] = 64'h22;
    expect_val("col_conf", K_CFA, 0, 1);
    expect_val("col_winner", K_RDA, 0, 64'h22);
    drain();
    tick();
    expect_val("col_conf_pulse", K_CFA, 0, 0);
    drain();

    a_w(0, 1'b1, 0, 64'h1);
    a_w(1, 1'b1, 0, 64'h2);
    tick();
    a_idle();
    expect_val("x0_no_conf", K_CFA, 0, 0);
    drain();

    a_w(0, 1'b1, 4, 64'h44);
    a_w(1, 1'b0, 4, 64'h99);
    tick();
    a_idle();
    model_a[4] = 64'h44;
    a_r(0, 4);
    expect_val("dis_port_no_conf", K_CFA, 0, 0);
    expect_val("dis_port_read", K_RDA, 0, 64'h44);
    drain();

    a_w(0, 1'b1, 1, 64'h1);
    a_w(1, 1'b1, 2, 64'h2);
    tick();
    a_idle();
    model_a[1] = 64'h1;
    model_a[2] = 64'h2;
    a_r(0, 1); a_r(1, 2); a_r(2, 2); a_r(3, 1);
    expect_val("par_p0", K_RDA, 0, 64'h1);
    expect_val("par_p1", K_RDA, 1, 64'h2);
    expect_val("par_p2", K_RDA, 2, 64'h2);
    expect_val("par_p3", K_RDA, 3, 64'h1);
    expect_val("par_conf", K_CFA, 0, 0);
    drain();

    for (int it = 0; it < 24; it++) begin
      e0  = 1'($urandom_range(0, 1));
      e1  = 1'($urandom_range(0, 1));
      ad0 = AW'($urandom_range(0, SZ - 1));
      ad1 = (it % 3 == 0) ? ad0 : AW'($urandom_range(0, SZ - 1));
      d0  = {$urandom, $urandom};
      d1  = {$urandom, $urandom};
      a_w(0, e0, ad0, d0);
      a_w(1, e1, ad1, d1);
      for (int q = 0; q < 4; q++) begin
        ra[q] = (q == 0) ? ad1 : AW'($urandom_range(0, SZ - 1));
        a_r(q, ra[q]);
        if (ra[q] == 0) ev = '0;
        else if (e1 && ad1 == ra[q]) ev = d1;
        else if (e0 && ad0 == ra[q]) ev = d0;
        else ev = model_a[ra[q]];
        expect_val($sformatf("rnd%0d_bp_p%0d", it, q), K_RDA, q, ev);
      end
      drain();
      tick();
      a_idle();
      if (e0 && ad0 != 0) model_a[ad0] = d0;
      if (e1 && ad1 != 0) model_a[ad1] = d1;
      expect_val($sformatf("rnd%0d_conf", it), K_CFA, 0, 64'(e0 && e1 && ad0 == ad1 && ad0 != 0));
      for (int q = 0; q < 4; q++) begin
        expect_val($sformatf("rnd%0d_rd_p%0d", it, q), K_RDA, q, model_a[ra[q]]);
      end
      drain();
    end

    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_r(0, 1); a_r(1, 7); a_r(2, 9); a_r(3, 2);
    b_r(0, 3);
    expect_val("mid_rst_ready_a", K_RDYA, 0, 0);
    expect_val("mid_rst_ready_b", K_RDYB, 0, 0);
    expect_val("mid_rst_rd_p0", K_RDA, 0, 0);
    expect_val("mid_rst_rd_p1", K_RDA, 1, 0);
    expect_val("mid_rst_rd_b", K_RDB, 0, 0);
    drain();
    for (int e = 1; e <= 31; e++) begin
      tick();
      if (e >= 30) begin
        expect_val($sformatf("reclr_ready_a_e%0d", e), K_RDYA, 0, 64'(e == 31));
        expect_val($sformatf("reclr_ready_b_e%0d", e), K_RDYB, 0, 64'(e == 31));
        drain();
      end
    end
    for (int r = 1; r < SZ; r++) begin
      a_r(r % 4, AW'(r));
      b_r(0, AW'(r));
      expect_val($sformatf("reclr_zero_a_x%0d", r), K_RDA, r % 4, 0);
      expect_val($sformatf("reclr_zero_b_x%0d", r), K_RDB, 0, 0);
      drain();
    end

    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 14; e++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 31; e++) begin
      tick();
      if (e == 17 || e >= 30) begin
        expect_val($sformatf("restart_ready_a_e%0d", e), K_RDYA, 0, 64'(e == 31));
        drain();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Multi-port, parametrised integer register file for the RISC-V core; successor to the single-write, dual-read bank.
- Adds configurable read and write port counts, hardwired-zero x0, and optional write-to-read bypass.
- Adds deterministic write-collision priority with a collision flag, and a post-reset clear sequencer with a ready indication.
- Sits between decode (read addresses) and writeback (write ports); the pipeline stalls until ready=1.

Parameters:
- WORDSIZE, 64, register width in bits
- SIZE, 32, number of registers (power of two, >=2)
- NREAD, 2, number of asynchronous read ports
- NWRITE, 1, number of synchronous write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads return stored value
- ADDRW (localparam), $clog2(SIZE), address width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- write_en  in  NWRITE  per-port write enable
- write_addr  in  NWRITE*ADDRW  per-port write address, port p at slice [p*ADDRW +: ADDRW]
- write_data  in  NWRITE*WORDSIZE  per-port write data, port p at [p*WORDSIZE +: WORDSIZE]
- read_addr  in  NREAD*ADDRW  per-port read address
- read_data  out  NREAD*WORDSIZE  per-port read data, combinational
- ready  out  1  1 = clear sequence done, writes accepted
- write_conflict  out  1  registered pulse: previous cycle had two or more enabled writes to the same nonzero address

Behaviour:
- Reset: single clock clk, synchronous active-high reset.
  - While reset=1 at a clk edge: state<=CLEAR, clr_idx<=1, ready<=0, write_conflict<=0.
  - Register contents are not reset directly.
- CLEAR state:
  - Each edge with reset=0 writes reg[clr_idx]<=0 and increments clr_idx.
  - On the edge where clr_idx==SIZE-1, state<=READY.
  - ready=1 exactly SIZE-1 edges after the first edge with reset=0 (31 for SIZE=32).
  - All write ports are ignored; all read_data=0.
  - Reset asserted mid-CLEAR restarts at clr_idx=1.
- READY state: stays until reset. ready = (state==READY).
- x0:
  - Address 0 always reads 0.
  - Writes to address 0 are discarded, never bypassed, and never flagged as a conflict.
- Writes (READY only):
  - At each edge, each enabled port p with nonzero addr updates reg[addr].
  - If several enabled ports target the same address, the highest port index wins.
  - Distinct addresses all update in the same cycle.
- Reads:
  - Purely combinational, zero latency.
  - BYPASS=1: if read_addr matches an enabled nonzero write_addr in the same cycle (READY), read_data = winning port's write_data.
  - Otherwise read_data = stored value.
  - BYPASS=0: always the stored value; the new value is visible the cycle after the edge.
- write_conflict:
  - Registered; 1 for exactly one cycle after any edge in READY at which >=2 enabled ports shared a nonzero address.
  - 0 otherwise, including throughout CLEAR.
  - Always 0 when NWRITE=1.
- Widths: no arithmetic. Address bits beyond SIZE do not exist (ADDRW exact). Data is stored unmodified.

Decomposition:
- Shared package rf_pkg holds:
  - the state enum (CLEAR, READY)
  - a function computing the winning write port for a given address (shared by the write and bypass paths)
- One natural sub-module: rf_clear_seq. It contains the FSM and clr_idx counter, and outputs clr_en, clr_addr and ready.
- Storage and port muxing stay in the top level; the existing n_bits_register is not reused (multi-write needs a mux-in per entry).

Test Plan:
- Reset, then idle (SIZE=32): ready=0 for 31 edges after reset release, 1 at edge 31; all read_data=0 during CLEAR; write_en=1 addr 5 data 0xAA at edge 10 is ignored, so reg5 reads 0 after ready.
- Basic write/read (NWRITE=1, BYPASS=0): write reg3=0x1234 → read port0 addr3 returns old 0 in the same cycle and 0x1234 the next; read addr0 returns 0 after a write of 0xFF to x0.
- Bypass (BYPASS=1): write reg7=0xDEADBEEF with read_addr port1=7 in the same cycle → read_data port1=0xDEADBEEF combinationally; port0 addr 0 with write addr 0 → 0.
- Collision (NWRITE=2): port0 writes reg9=0x11 and port1 writes reg9=0x22 → reg9=0x22, write_conflict=1 next cycle only; both ports to x0 → write_conflict stays 0.
- Parallel writes (NWRITE=2, NREAD=4): reg1=0x1 and reg2=0x2 on the same edge → both readable the next cycle on any port, write_conflict=0.
- Reset mid-operation: after ready, regs hold data; assert reset one cycle → ready=0, reads 0, full 31-edge clear, then reg1..reg31 all read 0; reset during clear at clr_idx=15 restarts the count.
